// File: rtl/delay_measure_pkg.sv
// Shared types for the probe-latency measurement block: FSM state encoding
// and the helper that sizes the latency counter from its saturation limit.
package delay_measure_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT,
        DONE
    } state_e;

    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/delay_measure.sv
// Launches a one-cycle probe word into a datapath and counts cycles until it
// returns. Optional mismatch flag is enabled by DELAY_MEASURE_MISMATCH_EN.
module delay_measure
    import delay_measure_pkg::*;
#(
    parameter int num_bits   = 8,
    parameter int max_cycles = 255,
    parameter int count_bits = count_width(max_cycles)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [num_bits-1:0]   pattern,
    output logic [num_bits-1:0]   probe_out,
    input  logic [num_bits-1:0]   probe_in,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [count_bits-1:0] latency
`ifdef DELAY_MEASURE_MISMATCH_EN
    ,
    output logic                  mismatch
`endif
);

    localparam logic [count_bits-1:0] MaxCount = count_bits'(max_cycles);

    state_e                state_q, state_d;
    logic [count_bits-1:0] count_q, count_d;
    logic [num_bits-1:0]   pattern_q, pattern_d;
    logic [num_bits-1:0]   probe_out_q, probe_out_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  timeout_q, timeout_d;
    logic [count_bits-1:0] latency_q, latency_d;
    logic                  match;

    assign match = (probe_in == pattern_q);

`ifdef DELAY_MEASURE_MISMATCH_EN
    logic mismatch_q, mismatch_d;
    logic foreign_word;

    // A nonzero word that is not the probe means the path corrupted or
    // injected data while the measurement was in flight.
    assign foreign_word = (probe_in != '0) && !match;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            pattern_q   <= '0;
            probe_out_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            latency_q   <= '0;
`ifdef DELAY_MEASURE_MISMATCH_EN
            mismatch_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            pattern_q   <= pattern_d;
            probe_out_q <= probe_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            latency_q   <= latency_d;
`ifdef DELAY_MEASURE_MISMATCH_EN
            mismatch_q  <= mismatch_d;
`endif
        end
    end

    // Outputs are computed one cycle ahead so every port comes from a flop.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        pattern_d   = pattern_q;
        probe_out_d = '0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        timeout_d   = timeout_q;
        latency_d   = latency_q;
`ifdef DELAY_MEASURE_MISMATCH_EN
        mismatch_d  = mismatch_q;
`endif

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start && (pattern != '0)) begin
                    pattern_d   = pattern;
                    probe_out_d = pattern;
                    timeout_d   = 1'b0;
                    busy_d      = 1'b1;
                    count_d     = '0;
                    state_d     = SEND;
`ifdef DELAY_MEASURE_MISMATCH_EN
                    mismatch_d  = 1'b0;
`endif
                end
            end
            SEND: begin
`ifdef DELAY_MEASURE_MISMATCH_EN
                if (foreign_word) mismatch_d = 1'b1;
`endif
                if (match) begin
                    latency_d = '0;
                    timeout_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end else begin
                    count_d   = count_bits'(1);
                    state_d   = WAIT;
                end
            end
            WAIT: begin
`ifdef DELAY_MEASURE_MISMATCH_EN
                if (foreign_word) mismatch_d = 1'b1;
`endif
                // A match on the final permitted cycle still counts as a match.
                if (match) begin
                    latency_d = count_q;
                    timeout_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end else if (count_q == MaxCount) begin
                    latency_d = MaxCount;
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end else begin
                    count_d   = count_q + count_bits'(1);
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign probe_out = probe_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign latency   = latency_q;
`ifdef DELAY_MEASURE_MISMATCH_EN
    assign mismatch  = mismatch_q;
`endif

endmodule

// File: tb/tb_delay_measure.sv
// Self-checking bench for delay_measure: the path under test is a tb-side
// delay line, wire, or tied-zero path; define DELAY_MEASURE_MISMATCH_EN for the mismatch flag.
module tb_delay_measure;

    localparam int NumBits   = 8;
    localparam int MaxCycles = 15;
    localparam int CountBits = $clog2(MaxCycles + 1);
    localparam int LineDepth = 20;

    logic                 clk;
    logic                 reset;
    logic                 start;
    logic [NumBits-1:0]   pattern;
    logic [NumBits-1:0]   probeOut;
    logic [NumBits-1:0]   probeIn;
    logic                 busy;
    logic                 done;
    logic                 timeout;
    logic [CountBits-1:0] latency;
`ifdef DELAY_MEASURE_MISMATCH_EN
    logic                 mismatch;
`endif

    // Path under test: 0 = registered delay line, 1 = wire, 2 = tied to zero
    int                   pathMode;
    int                   delaySel;
    logic                 injectEn;
    logic [NumBits-1:0]   injectVal;
    logic [NumBits-1:0]   delayLine [0:LineDepth-1];

    int checks;
    int passed;

    delay_measure #(
        .num_bits   (NumBits),
        .max_cycles (MaxCycles)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pattern   (pattern),
        .probe_out (probeOut),
        .probe_in  (probeIn),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .latency   (latency)
`ifdef DELAY_MEASURE_MISMATCH_EN
        ,
        .mismatch  (mismatch)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        delayLine[0] <= probeOut;
        for (int i = 1; i < LineDepth; i++) delayLine[i] <= delayLine[i-1];
    end

    always_comb begin
        probeIn = '0;
        if (injectEn) probeIn = injectVal;
        else if (pathMode == 1) probeIn = probeOut;
        else if (pathMode == 0 && delaySel >= 1 && delaySel <= LineDepth) probeIn = delayLine[delaySel-1];
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed %0d required %0d", tag, obs, exp);
    endtask

    // One measurement: a path returning after L cycles gives done in cycle L+2
    // (counting the start cycle as 0) and busy for L+2 cycles.
    task automatic applyStimulus(input logic [NumBits-1:0] pat, input int mode, input int dsel,
                                 input int expLat, input bit expTo, input string tag);
        int c;
        int doneAt;
        int busyCnt;
        pathMode = mode;
        delaySel = dsel;
        pattern  = pat;
        start    = 1'b1;
        stepCycle();
        start    = 1'b0;
        c        = 1;
        doneAt   = -1;
        busyCnt  = 0;
        checkOutput({tag, "_timeoutCleared"}, 32'(timeout), 32'd0);
        while (doneAt < 0 && c <= 40) begin
            if (busy) busyCnt++;
            if (done) doneAt = c;
            else begin
                stepCycle();
                c++;
            end
        end
        checkOutput({tag, "_doneCycle"}, 32'(doneAt), 32'(expLat + 2));
        checkOutput({tag, "_busyCycles"}, 32'(busyCnt), 32'(expLat + 2));
        checkOutput({tag, "_latency"}, 32'(latency), 32'(expLat));
        checkOutput({tag, "_timeout"}, 32'(timeout), 32'(expTo));
`ifdef DELAY_MEASURE_MISMATCH_EN
        checkOutput({tag, "_mismatch"}, 32'(mismatch), 32'd0);
`endif
        stepCycle();
        checkOutput({tag, "_doneDrop"}, 32'(done), 32'd0);
        checkOutput({tag, "_busyDrop"}, 32'(busy), 32'd0);
        repeat (LineDepth + 2) stepCycle();
    endtask

    initial begin
        int d;
        int expLat;
        bit expTo;
        int doneCnt;
        logic [NumBits-1:0] pat;

        checks    = 0;
        passed    = 0;
        reset     = 1'b1;
        start     = 1'b0;
        pattern   = '0;
        pathMode  = 2;
        delaySel  = 1;
        injectEn  = 1'b0;
        injectVal = '0;
        repeat (LineDepth + 2) stepCycle();
        checkOutput("reset_probeOut", 32'(probeOut), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_latency", 32'(latency), 32'd0);
        reset = 1'b0;
        stepCycle();

        applyStimulus(8'hA5, 0, 5, 5, 1'b0, "delay5");
        applyStimulus(8'h3C, 1, 1, 0, 1'b0, "wire");
        applyStimulus(8'h77, 2, 1, MaxCycles, 1'b1, "tiedZero");
        applyStimulus(8'hC3, 0, MaxCycles, MaxCycles, 1'b0, "matchAtMax");

        // Zero pattern must never be accepted
        pattern  = '0;
        start    = 1'b1;
        pathMode = 1;
        repeat (3) begin
            stepCycle();
            checkOutput("zeroPattern_busy", 32'(busy), 32'd0);
        end
        start = 1'b0;
        stepCycle();

        // Start held high: one done, then a fresh measurement from IDLE
        pathMode = 0;
        delaySel = 5;
        pattern  = 8'hA5;
        start    = 1'b1;
        stepCycle();
        doneCnt = 0;
        for (int c = 1; c <= 9; c++) begin
            if (c <= 8) doneCnt += 32'(done);
            if (c == 8) checkOutput("heldStart_idleGap", 32'(busy), 32'd0);
            if (c == 9) checkOutput("heldStart_restart", 32'(busy), 32'd1);
            if (c < 9) stepCycle();
        end
        start = 1'b0;
        checkOutput("heldStart_doneCount", 32'(doneCnt), 32'd1);
        repeat (LineDepth + 4) stepCycle();

        // Reset while waiting at count 3
        pattern = 8'hA5;
        start   = 1'b1;
        stepCycle();
        start = 1'b0;
        repeat (3) stepCycle();
        checkOutput("midReset_busyBefore", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("midReset_probeOut", 32'(probeOut), 32'd0);
        checkOutput("midReset_busy", 32'(busy), 32'd0);
        checkOutput("midReset_done", 32'(done), 32'd0);
        checkOutput("midReset_timeout", 32'(timeout), 32'd0);
        checkOutput("midReset_latency", 32'(latency), 32'd0);
        stepCycle();
        reset   = 1'b0;
        doneCnt = 0;
        repeat (LineDepth) begin
            stepCycle();
            doneCnt += 32'(done);
        end
        checkOutput("midReset_noDone", 32'(doneCnt), 32'd0);

`ifdef DELAY_MEASURE_MISMATCH_EN
        // Foreign word at count 2 before the probe returns at 5
        pathMode = 0;
        delaySel = 5;
        pattern  = 8'hA5;
        start    = 1'b1;
        stepCycle();
        start = 1'b0;
        stepCycle();
        stepCycle();
        injectVal = 8'h5A;
        injectEn  = 1'b1;
        stepCycle();
        injectEn = 1'b0;
        repeat (3) stepCycle();
        checkOutput("mismatch_done", 32'(done), 32'd1);
        checkOutput("mismatch_latency", 32'(latency), 32'd5);
        checkOutput("mismatch_flag", 32'(mismatch), 32'd1);
        repeat (LineDepth + 2) stepCycle();
`endif

        // Random paths checked against the plain latency rule
        for (int t = 0; t < 24; t++) begin
            d   = $urandom_range(0, LineDepth);
            pat = NumBits'($urandom_range(1, 255));
            if (d == 0) begin
                expLat = 0;
                expTo  = 1'b0;
            end else if (d <= MaxCycles) begin
                expLat = d;
                expTo  = 1'b0;
            end else begin
                expLat = MaxCycles;
                expTo  = 1'b1;
            end
            applyStimulus(pat, (d == 0) ? 1 : 0, (d == 0) ? 1 : d, expLat, expTo, $sformatf("rand%0d", t));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
